// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-MM block mover.
package avl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      DONE_ST
   } state_t;

   localparam logic [3:0]  BYTE_EN_ALL = 4'b1111;
   localparam int unsigned WORD_BYTES  = 4;

   // Byte address of word idx in a block starting at base (32-bit modulo).
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + idx * WORD_BYTES;
   endfunction

endpackage

// File: rtl/avl_watchdog.sv
// Read-data watchdog: reloaded on read acceptance, counts down while waiting.
// o_expire marks the last cycle in which read data may still be taken.
module avl_watchdog #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   // Reload on clear, otherwise decrement while enabled, stopping at zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= LOAD;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_expire = (r_cnt == CW'(1));

endmodule

// File: rtl/avl_block_mover.sv
// Avalon-MM master copying COUNT 32-bit words from SRC_BASE to DST_BASE,
// one read followed by one write per word, with a read-data timeout.
module avl_block_mover
   import avl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [31:0]      SRC_BASE,
   input  logic [31:0]      DST_BASE,
   input  logic [CNT_W-1:0] COUNT,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [31:0]      AVM_ADDR,
   output logic             AVM_READ,
   output logic             AVM_WRITE,
   output logic [3:0]       AVM_BYTE_EN,
   output logic [31:0]      AVM_WRITEDATA,
   input  logic [31:0]      AVM_READDATA,
   input  logic             AVM_WAITREQUEST,
   input  logic             AVM_READDATAVALID
);

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_src, w_src_nxt;
   logic [31:0]      r_dst, w_dst_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_idx, w_idx_nxt;
   logic [31:0]      r_hold, w_hold_nxt;
   logic [31:0]      r_addr, w_addr_nxt;
   logic             r_err, w_err_nxt;
   logic             r_rd, w_rd_nxt;
   logic             r_wr, w_wr_nxt;
   logic [3:0]       r_be, w_be_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             w_wd_clr, w_wd_en, w_expire, w_last;

   avl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .i_clk    (CLK),
      .i_rst_n  (RESET_N),
      .i_clr    (w_wd_clr),
      .i_en     (w_wd_en),
      .o_expire (w_expire)
   );

   assign w_last = (r_idx == (r_cnt - CNT_W'(1)));

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus next values of every registered output, so the bus
   // signals seen in a state are already valid in its first cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_hold_nxt  = r_hold;
      w_addr_nxt  = r_addr;
      w_err_nxt   = r_err;
      w_rd_nxt    = 1'b0;
      w_wr_nxt    = 1'b0;
      w_be_nxt    = '0;
      w_wd_clr    = 1'b0;
      w_wd_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_src_nxt = SRC_BASE;
               w_dst_nxt = DST_BASE;
               w_cnt_nxt = COUNT;
               w_idx_nxt = '0;
               w_err_nxt = 1'b0;
               if (COUNT != '0) begin
                  w_state_nxt = RD_REQ;
                  w_rd_nxt    = 1'b1;
                  w_be_nxt    = BYTE_EN_ALL;
                  w_addr_nxt  = SRC_BASE;
               end else begin
                  w_state_nxt = DONE_ST;
               end
            end
         end
         RD_REQ: begin
            if (AVM_WAITREQUEST) begin
               w_rd_nxt = 1'b1;
               w_be_nxt = BYTE_EN_ALL;
            end else begin
               w_state_nxt = RD_WAIT;
               w_wd_clr    = 1'b1;
            end
         end
         RD_WAIT: begin
            w_wd_en = 1'b1;
            if (AVM_READDATAVALID) begin
               w_hold_nxt  = AVM_READDATA;
               w_state_nxt = WR_REQ;
               w_wr_nxt    = 1'b1;
               w_be_nxt    = BYTE_EN_ALL;
               w_addr_nxt  = word_addr(r_dst, 32'(r_idx));
            end else if (w_expire) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = DONE_ST;
            end
         end
         WR_REQ: begin
            if (AVM_WAITREQUEST) begin
               w_wr_nxt = 1'b1;
               w_be_nxt = BYTE_EN_ALL;
            end else if (w_last) begin
               w_state_nxt = DONE_ST;
            end else begin
               w_idx_nxt   = r_idx + CNT_W'(1);
               w_state_nxt = RD_REQ;
               w_rd_nxt    = 1'b1;
               w_be_nxt    = BYTE_EN_ALL;
               w_addr_nxt  = word_addr(r_src, 32'(r_idx) + 32'd1);
            end
         end
         DONE_ST: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
      w_done_nxt = (w_state_nxt == DONE_ST);
   end

   // Datapath and output registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_cnt  <= '0;
         r_idx  <= '0;
         r_hold <= '0;
         r_addr <= '0;
         r_err  <= 1'b0;
         r_rd   <= 1'b0;
         r_wr   <= 1'b0;
         r_be   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_src  <= w_src_nxt;
         r_dst  <= w_dst_nxt;
         r_cnt  <= w_cnt_nxt;
         r_idx  <= w_idx_nxt;
         r_hold <= w_hold_nxt;
         r_addr <= w_addr_nxt;
         r_err  <= w_err_nxt;
         r_rd   <= w_rd_nxt;
         r_wr   <= w_wr_nxt;
         r_be   <= w_be_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign BUSY          = r_busy;
   assign DONE          = r_done;
   assign ERR           = r_err;
   assign AVM_ADDR      = r_addr;
   assign AVM_READ      = r_rd;
   assign AVM_WRITE     = r_wr;
   assign AVM_BYTE_EN   = r_be;
   assign AVM_WRITEDATA = r_hold;

endmodule

// File: tb/tb_avl_block_mover.sv
// Bench for avl_block_mover: an Avalon slave with memory, configurable stalls
// and read latency, plus a word-by-word copy reference and a cycle-count model.
module tb_avl_block_mover;

   localparam int unsigned TO = 16;
   localparam int unsigned CW = 8;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } xact_t;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          START;
   logic [31:0]   SRC_BASE, DST_BASE;
   logic [CW-1:0] COUNT;
   logic          BUSY, DONE, ERR;
   logic [31:0]   AVM_ADDR;
   logic          AVM_READ, AVM_WRITE;
   logic [3:0]    AVM_BYTE_EN;
   logic [31:0]   AVM_WRITEDATA, AVM_READDATA;
   logic          AVM_WAITREQUEST, AVM_READDATAVALID;

   avl_block_mover #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .CLK               (CLK),
      .RESET_N           (RESET_N),
      .START             (START),
      .SRC_BASE          (SRC_BASE),
      .DST_BASE          (DST_BASE),
      .COUNT             (COUNT),
      .BUSY              (BUSY),
      .DONE              (DONE),
      .ERR               (ERR),
      .AVM_ADDR          (AVM_ADDR),
      .AVM_READ          (AVM_READ),
      .AVM_WRITE         (AVM_WRITE),
      .AVM_BYTE_EN       (AVM_BYTE_EN),
      .AVM_WRITEDATA     (AVM_WRITEDATA),
      .AVM_READDATA      (AVM_READDATA),
      .AVM_WAITREQUEST   (AVM_WAITREQUEST),
      .AVM_READDATAVALID (AVM_READDATAVALID)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // slave configuration
   bit rand_mode = 1'b0;
   bit no_valid  = 1'b0;
   int stall_rd  = 0;
   int stall_wr  = 0;
   int lat_cfg   = 1;

   // slave state
   logic [31:0] mem [bit [31:0]];
   xact_t       log_q[$];
   bit          in_req = 1'b0;
   int          stall_left = 0;
   int          rdv_cnt = 0;
   logic [31:0] rd_pend = '0;
   logic [31:0] cap_addr, cap_wd;
   logic [5:0]  cap_ctl;
   int          extra = 0;
   int          rd_acc_cyc = 0;

   // monitors and command driving
   bit start_req = 1'b0;
   bit repulse_req = 1'b0;
   int start_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int first_busy = -1;
   int last_busy = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: at the falling edge drive the command, watch DONE/BUSY
   // and play the slave side of the bus for this cycle.
   task automatic step();
      int    lat;
      xact_t x;
      @(negedge CLK);
      START = start_req | repulse_req;
      if (start_req) start_cyc = cyc;
      start_req = 1'b0;
      if (DONE) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (BUSY) begin
         if (first_busy < 0) first_busy = cyc;
         last_busy = cyc;
      end
      AVM_READDATAVALID = 1'b0;
      AVM_READDATA      = $urandom;
      if (rdv_cnt > 0) begin
         rdv_cnt--;
         if (rdv_cnt == 0) begin
            AVM_READDATAVALID = 1'b1;
            AVM_READDATA      = rd_pend;
         end
      end else if (rand_mode && !no_valid && ($urandom_range(0, 3) == 0)) begin
         AVM_READDATAVALID = 1'b1;
      end
      AVM_WAITREQUEST = 1'b0;
      if (AVM_READ || AVM_WRITE) begin
         chk("rd_wr_excl", 32'(AVM_READ & AVM_WRITE), 32'd0);
         if (!in_req) begin
            in_req     = 1'b1;
            stall_left = rand_mode ? int'($urandom_range(0, 3)) : (AVM_READ ? stall_rd : stall_wr);
            extra     += stall_left;
            cap_addr   = AVM_ADDR;
            cap_wd     = AVM_WRITEDATA;
            cap_ctl    = {AVM_READ, AVM_WRITE, AVM_BYTE_EN};
         end else begin
            chk("stall_addr", AVM_ADDR, cap_addr);
            chk("stall_ctl", 32'({AVM_READ, AVM_WRITE, AVM_BYTE_EN}), 32'(cap_ctl));
            if (AVM_WRITE) chk("stall_wdata", AVM_WRITEDATA, cap_wd);
         end
         if (stall_left > 0) begin
            AVM_WAITREQUEST = 1'b1;
            stall_left--;
         end else begin
            in_req = 1'b0;
            chk("byte_en", 32'(AVM_BYTE_EN), 32'hF);
            x.addr = AVM_ADDR;
            if (AVM_READ) begin
               x.wr = 1'b0;
               x.data = '0;
               rd_acc_cyc = cyc;
               lat = rand_mode ? int'($urandom_range(1, TO - 1)) : lat_cfg;
               extra += lat - 1;
               rd_pend = mem.exists(AVM_ADDR) ? mem[AVM_ADDR] : (AVM_ADDR ^ 32'h5A5A_0000);
               if (!no_valid) rdv_cnt = lat;
            end else begin
               x.wr = 1'b1;
               x.data = AVM_WRITEDATA;
               mem[AVM_ADDR] = AVM_WRITEDATA;
            end
            log_q.push_back(x);
         end
      end
   endtask

   // Run one transfer and compare the bus log, DONE/BUSY timing and ERR
   // against a sequential copy reference and the cycle-count rules.
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input int repulse_at);
      logic [31:0] ref_mem [bit [31:0]];
      xact_t       exp_q[$];
      xact_t       x;
      logic [31:0] a, v;
      int          budget, exp_done, n;
      for (int i = 0; i < cnt; i++) begin
         a = src + 32'(i) * 4;
         if (!mem.exists(a)) mem[a] = $urandom;
      end
      ref_mem = mem;
      for (int i = 0; i < cnt; i++) begin
         v = ref_mem[src + 32'(i) * 4];
         x.wr = 1'b0; x.addr = src + 32'(i) * 4; x.data = '0;
         exp_q.push_back(x);
         if (no_valid) break;
         ref_mem[dst + 32'(i) * 4] = v;
         x.wr = 1'b1; x.addr = dst + 32'(i) * 4; x.data = v;
         exp_q.push_back(x);
      end
      log_q.delete();
      done_cnt = 0; first_busy = -1; last_busy = -1; extra = 0;
      SRC_BASE = src; DST_BASE = dst; COUNT = CW'(cnt);
      start_req = 1'b1;
      step();
      budget = 0;
      while (done_cnt == 0 && budget < 4000) begin
         if (repulse_at != 0 && budget == repulse_at) begin
            SRC_BASE = 32'h300; DST_BASE = 32'h380; COUNT = CW'(4);
            repulse_req = 1'b1;
         end
         step();
         repulse_req = 1'b0;
         if (budget == 0) begin
            SRC_BASE = $urandom; DST_BASE = $urandom; COUNT = CW'($urandom);
         end
         budget++;
      end
      repeat (3) step();
      exp_done = no_valid ? rd_acc_cyc + TO : start_cyc + 1 + 3 * cnt + extra;
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'(exp_done));
      chk("busy_first", 32'(first_busy), 32'(start_cyc + 1));
      chk("busy_last", 32'(last_busy), 32'(exp_done));
      chk("busy_idle", 32'(BUSY), 32'd0);
      chk("err_flag", 32'(ERR), 32'(no_valid));
      chk("xact_count", 32'(log_q.size()), 32'(exp_q.size()));
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("x%0d_kind", i), 32'(log_q[i].wr), 32'(exp_q[i].wr));
         chk($sformatf("x%0d_addr", i), log_q[i].addr, exp_q[i].addr);
         if (exp_q[i].wr) chk($sformatf("x%0d_data", i), log_q[i].data, exp_q[i].data);
      end
   endtask

   initial begin
      logic [31:0] s, d;
      int          budget;
      RESET_N = 1'b0; START = 1'b0; SRC_BASE = '0; DST_BASE = '0; COUNT = '0;
      AVM_READDATA = '0; AVM_WAITREQUEST = 1'b0; AVM_READDATAVALID = 1'b0;
      repeat (3) step();
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_read", 32'(AVM_READ), 32'd0);
      chk("rst_write", 32'(AVM_WRITE), 32'd0);
      chk("rst_addr", AVM_ADDR, 32'd0);
      chk("rst_be", 32'(AVM_BYTE_EN), 32'd0);
      chk("rst_wdata", AVM_WRITEDATA, 32'd0);
      RESET_N = 1'b1;
      step();

      // zero-wait, three words
      mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
      run_xfer(32'h100, 32'h200, 3, 0);
      chk("zw_latency", 32'(done_cyc - start_cyc), 32'd10);

      // every request held for three cycles
      stall_rd = 2; stall_wr = 2;
      run_xfer(32'h100, 32'h200, 3, 0);
      chk("stall_latency", 32'(done_cyc - start_cyc), 32'd22);
      stall_rd = 0; stall_wr = 0;

      // empty block
      run_xfer(32'h100, 32'h200, 0, 0);
      chk("cnt0_latency", 32'(done_cyc - start_cyc), 32'd1);

      // read data never returned
      no_valid = 1'b1;
      run_xfer(32'h600, 32'h700, 3, 0);
      chk("to_latency", 32'(done_cyc - rd_acc_cyc), 32'(TO));
      no_valid = 1'b0;
      repeat (4) step();
      chk("err_sticky", 32'(ERR), 32'd1);
      run_xfer(32'h640, 32'h740, 1, 0);

      // slowest read data that still beats the timeout
      lat_cfg = TO - 1;
      run_xfer(32'h800, 32'h900, 2, 0);
      lat_cfg = 1;

      // reset while a write is stalled
      stall_wr = 1000;
      SRC_BASE = 32'h400; DST_BASE = 32'h500; COUNT = CW'(3);
      start_req = 1'b1;
      step();
      budget = 0;
      while (!AVM_WRITE && budget < 50) begin
         step();
         budget++;
      end
      chk("rst_mid_reached", 32'(AVM_WRITE), 32'd1);
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_write", 32'(AVM_WRITE), 32'd0);
      chk("arst_busy", 32'(BUSY), 32'd0);
      chk("arst_done", 32'(DONE), 32'd0);
      in_req = 1'b0; rdv_cnt = 0; stall_wr = 0;
      repeat (2) step();
      RESET_N = 1'b1;
      step();
      run_xfer(32'h400, 32'h500, 2, 0);

      // START re-pulsed mid-transfer
      run_xfer(32'h1000, 32'h2000, 4, 3);

      // address wrap past the top of the space
      run_xfer(32'hFFFF_FFF8, 32'hFFFF_FFF0, 4, 0);

      // randomized stalls, latencies and stray readdatavalid
      rand_mode = 1'b1;
      for (int t = 0; t < 8; t++) begin
         s = $urandom & 32'hFFFF_FFFC;
         d = $urandom & 32'hFFFF_FFFC;
         if (t == 0) s = 32'hFFFF_FFE0;
         run_xfer(s, d, int'($urandom_range(1, 20)), 0);
      end
      rand_mode = 1'b0;

      // largest COUNT
      run_xfer(32'h0001_0000, 32'h0002_0000, 255, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
